dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Sequences and shares the single-port data memory (word array, combinational read, RWE-coded synchronous write) between two requesters: port 0 = core load/store unit, port 1 = DMA/debug.
- Round-robin arbitration, one transaction in flight, registered responses, out-of-range address checking.
- Sits between the LSU/DMA and the data memory. Drives the memory's A/WD/RWE inputs and samples RD.

Parameters:
- ADDR_W, 32, address width of requesters and memory.
- DATA_W, 32, data width.
- MEM_DEPTH, 64, number of valid memory words; addresses >= MEM_DEPTH are errors.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-port request valid.
- req_ready  out  2  per-port accept; at most one bit high.
- req_addr0 / req_addr1  in  ADDR_W  word address.
- req_wdata0 / req_wdata1  in  DATA_W  store data.
- req_op0 / req_op1  in  2  0=LOAD, 1=SB, 2=SH, 3=SW.
- rsp_valid  out  2  one-cycle response pulse, per port.
- rsp_rdata  out  DATA_W  load data; 0 for stores and errors.
- rsp_err  out  1  address out of range; valid with rsp_valid.
- mem_a  out  ADDR_W  to memory A.
- mem_wd  out  DATA_W  to memory WD.
- mem_rwe  out  2  to memory RWE; 0 = no write.
- mem_rd  in  DATA_W  from memory RD (combinational).

Behaviour:
- FSM states: IDLE, ACCESS, RESP (plus MERGE when the optional feature is enabled).
- IDLE or RESP: req_ready is combinational from the arbiter and is raised only for the winning valid port.
  - On handshake (valid & ready) in cycle T: latch addr, wdata, op and owner; go to ACCESS.
  - Otherwise go to IDLE.
- ACCESS (T+1): drive mem_a = latched addr.
  - LOAD: mem_rwe = 0; register mem_rd.
  - Store: mem_rwe = op, mem_wd = wdata.
  - Then go to RESP.
- RESP (T+2): rsp_valid[owner] = 1 for exactly this cycle, with rsp_rdata and rsp_err. A new request may be accepted in the same cycle, giving 2-cycle throughput.
- Outside ACCESS: mem_rwe = 0, and mem_a and mem_wd hold their last values.
- Arbitration: a bit last_grant.
  - Both valid: grant the port != last_grant.
  - One valid: grant it.
  - last_grant updates on each handshake.
  - req_valid must stay asserted until ready. A requester that drops valid before ready loses nothing.
- Range check: addr >= MEM_DEPTH forces mem_rwe = 0 in ACCESS, and RESP returns rdata = 0, rsp_err = 1.
- Reset values: state = IDLE, last_grant = 1 (port 0 wins first), req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, mem_a = 0, mem_wd = 0, mem_rwe = 0.
- Reset mid-transaction: the transaction is aborted and no response is issued. A write is suppressed unless rst falls in the ACCESS cycle after the edge.
- rsp_rdata and rsp_err are zero whenever rsp_valid = 0.

Optional Feature:
- Macro: DMEM_RMW_EN.
- Defined: SB/SH become read-modify-write.
  - ACCESS reads mem_rd and goes to MERGE.
  - MERGE writes with mem_rwe = 3 and mem_wd = {mem_word[31:8], wdata[7:0]} for SB, or {mem_word[31:16], wdata[15:0]} for SH.
  - Then go to RESP; SB/SH latency rises to 3 cycles.
  - Out-of-range SB/SH skip MERGE.
- Undefined: SB/SH are passed through as mem_rwe = 1/2, and the memory sign-extends into the full word. No MERGE state exists.

Decomposition:
- Package dmem_pkg holds:
  - op encoding constants (OP_LOAD, OP_SB, OP_SH, OP_SW) shared with the memory's RWE;
  - FSM state typedef;
  - default width constants.
- Sub-module rr_arb2: two-input round-robin arbiter. Inputs: req[1:0], last_grant, enable. Output: one-hot grant.

Test Plan:
- Port 0 LOAD addr 20 after reset, memory holds 15 -> req_ready[0] at T; rsp_valid[0] at T+2 with rsp_rdata = 15, rsp_err = 0.
- Both ports valid continuously, port 0 LOAD 16, port 1 LOAD 24 -> grants alternate 0,1,0,1 and responses return 65340 and 243 in the same order.
- Port 1 SW addr 5, wdata 0xDEADBEEF, then port 1 LOAD 5 -> mem_rwe = 3 for one cycle; the load returns 0xDEADBEEF.
- Port 0 SB addr 28, wdata 0x80, memory holds 16772668:
  - with DMEM_RMW_EN -> word becomes 0x00FFEE80;
  - without DMEM_RMW_EN -> mem_rwe = 1 and the word becomes 0xFFFFFF80.
- Port 0 SW addr 64 -> mem_rwe stays 0; rsp_err = 1 and rsp_rdata = 0 at T+2; memory unchanged.
- rst asserted in the ACCESS cycle of an SW -> no rsp_valid, outputs zeroed; the next simultaneous request grants port 0 first.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter: op/RWE encoding, FSM state codes, default widths.
package dmem_pkg;

  localparam int ADDR_W_DEF    = 32;
  localparam int DATA_W_DEF    = 32;
  localparam int MEM_DEPTH_DEF = 64;

  // Op codes double as the memory RWE code for stores
  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_SB   = 2'd1;
  localparam logic [1:0] OP_SH   = 2'd2;
  localparam logic [1:0] OP_SW   = 2'd3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_RESP   = 2'd2;
  localparam state_t ST_MERGE  = 2'd3;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: on contention the port that did not win last time is granted.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (req == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
      else              grant = req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin sharing of a single-port data memory between LSU (port 0) and DMA/debug (port 1).
// DMEM_RMW_EN: when defined, SB/SH become read-modify-write through an extra MERGE cycle.
//
// state  | meaning
// IDLE   | no transaction in flight, arbiter open
// ACCESS | memory addressed; load data captured or store written
// MERGE  | (DMEM_RMW_EN only) merged full-word write for SB/SH
// RESP   | response pulse; arbiter open for the next request
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  input  logic [1:0]        req_op0,
  input  logic [1:0]        req_op1,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  output logic [1:0]        mem_rwe,
  input  logic [DATA_W-1:0] mem_rd
);

  state_t            state;
  logic              last_grant;
  logic              owner;
  logic              err_q;
  logic [1:0]        op_q;
  logic [1:0]        grant;
  logic              arb_en;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [1:0]        sel_op;

  assign arb_en    = !rst && (state == ST_IDLE || state == ST_RESP);
  assign req_ready = grant;
  assign sel_addr  = grant[1] ? req_addr1  : req_addr0;
  assign sel_wdata = grant[1] ? req_wdata1 : req_wdata0;
  assign sel_op    = grant[1] ? req_op1    : req_op0;

  rr_arb2 u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .enable     (arb_en),
    .grant      (grant)
  );

`ifdef DMEM_RMW_EN
  logic [DATA_W-1:0] wdata_q;
  logic              rmw_go;
  logic [DATA_W-1:0] merged;

  assign rmw_go = !err_q && (op_q == OP_SB || op_q == OP_SH);
  assign merged = (op_q == OP_SB) ? {mem_rd[DATA_W-1:8],  wdata_q[7:0]}
                                  : {mem_rd[DATA_W-1:16], wdata_q[15:0]};
`endif

  // rst gates the write so a reset seen at the end of ACCESS aborts the store
  always_comb begin
    mem_rwe = 2'b00;
    if (!rst && !err_q) begin
`ifdef DMEM_RMW_EN
      if (state == ST_ACCESS && op_q == OP_SW) mem_rwe = OP_SW;
      if (state == ST_MERGE)                   mem_rwe = OP_SW;
`else
      if (state == ST_ACCESS) mem_rwe = op_q;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      err_q      <= 1'b0;
      op_q       <= OP_LOAD;
      mem_a      <= '0;
      mem_wd     <= '0;
      rsp_valid  <= 2'b00;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
`ifdef DMEM_RMW_EN
      wdata_q    <= '0;
`endif
    end else begin
      rsp_valid <= 2'b00;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      case (state)
        ST_IDLE, ST_RESP: begin
          if (|grant) begin
            state      <= ST_ACCESS;
            owner      <= grant[1];
            last_grant <= grant[1];
            mem_a      <= sel_addr;
            mem_wd     <= sel_wdata;
            op_q       <= sel_op;
            err_q      <= !(sel_addr < ADDR_W'(MEM_DEPTH));
`ifdef DMEM_RMW_EN
            wdata_q    <= sel_wdata;
`endif
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
`ifdef DMEM_RMW_EN
          if (rmw_go) begin
            state  <= ST_MERGE;
            mem_wd <= merged;
          end else
`endif
          begin
            state     <= ST_RESP;
            rsp_valid <= {owner, !owner};
            rsp_err   <= err_q;
            rsp_rdata <= (op_q == OP_LOAD && !err_q) ? mem_rd : '0;
          end
        end
`ifdef DMEM_RMW_EN
        ST_MERGE: begin
          state     <= ST_RESP;
          rsp_valid <= {owner, !owner};
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter against a transaction-level model of the memory and arbiter.
module tb_dmem_arbiter;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld0 = 1'b0, vld1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wd0 = '0, wd1 = '0;
  logic [1:0]  op0 = '0, op1 = '0;

  logic [1:0]  req_ready, rsp_valid, mem_rwe;
  logic [31:0] rsp_rdata, mem_a, mem_wd, mem_rd;
  logic        rsp_err;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  ({vld1, vld0}),
    .req_ready  (req_ready),
    .req_addr0  (addr0),
    .req_addr1  (addr1),
    .req_wdata0 (wd0),
    .req_wdata1 (wd1),
    .req_op0    (op0),
    .req_op1    (op1),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rwe    (mem_rwe),
    .mem_rd     (mem_rd)
  );

  // Memory device: combinational read, sign-extending sub-word writes
  logic [31:0] mem [0:DEPTH-1];
  assign mem_rd = (mem_a < DEPTH) ? mem[mem_a[5:0]] : 32'hBAD0_0000;
  always @(posedge clk) begin
    if (mem_rwe != 2'b00 && mem_a < DEPTH) begin
      case (mem_rwe)
        2'd1:    mem[mem_a[5:0]] <= {{24{mem_wd[7]}}, mem_wd[7:0]};
        2'd2:    mem[mem_a[5:0]] <= {{16{mem_wd[15]}}, mem_wd[15:0]};
        default: mem[mem_a[5:0]] <= mem_wd;
      endcase
    end
  end

  typedef struct {
    int          due;
    int          port;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic [31:0] ref_mem [0:DEPTH-1];
  rsp_t        exp_q[$];
  int          grant_log[$];
  int          cyc = 0, free_cyc = 0, wr_cyc = -1, lw = 1;
  int          acc0 = 0, acc1 = 0;
  logic [1:0]  wr_val;
  logic [31:0] wr_addr;
  int          total = 0, bad = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] store_result(input logic [31:0] old, input logic [1:0] o,
                                               input logic [31:0] d);
    case (o)
`ifdef DMEM_RMW_EN
      2'd1:    return {old[31:8], d[7:0]};
      2'd2:    return {old[31:16], d[15:0]};
`else
      2'd1:    return {{24{d[7]}}, d[7:0]};
      2'd2:    return {{16{d[15]}}, d[15:0]};
`endif
      default: return d;
    endcase
  endfunction

  // Transaction-level model: one request in flight, fixed latency, round-robin on contention
  logic [1:0]  mv, mer, mhs;
  logic [31:0] ma, md;
  logic [1:0]  mo;
  int          mp, mlat;
  rsp_t        me;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready", {30'd0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
      chk("rst_rwe", {30'd0, mem_rwe}, 32'd0);
      exp_q.delete();
      free_cyc = 0;
      wr_cyc   = -1;
      lw       = 1;
    end else begin
      mv  = {vld1, vld0};
      mer = 2'b00;
      if (cyc >= free_cyc) mer = (mv == 2'b11) ? ((lw == 1) ? 2'b01 : 2'b10) : mv;
      chk("ready", {30'd0, req_ready}, {30'd0, mer});
      chk("rwe", {30'd0, mem_rwe}, (cyc == wr_cyc) ? {30'd0, wr_val} : 32'd0);
      if (cyc == wr_cyc) chk("mem_a", mem_a, wr_addr);

      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        me = exp_q.pop_front();
        chk("rsp_valid", {30'd0, rsp_valid}, (me.port == 1) ? 32'd2 : 32'd1);
        chk("rsp_rdata", rsp_rdata, me.rdata);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, me.err});
      end else begin
        chk("rsp_idle_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rsp_idle_data", rsp_rdata | {31'd0, rsp_err}, 32'd0);
      end

      mhs = mv & mer;
      if (mhs != 2'b00) begin
        mp   = mhs[1] ? 1 : 0;
        ma   = (mp == 1) ? addr1 : addr0;
        md   = (mp == 1) ? wd1 : wd0;
        mo   = (mp == 1) ? op1 : op0;
        mlat = 2;
        me.err   = (ma >= DEPTH);
        me.rdata = '0;
        if (!me.err) begin
          if (mo == 2'd0) begin
            me.rdata = ref_mem[ma[5:0]];
          end else begin
            ref_mem[ma[5:0]] = store_result(ref_mem[ma[5:0]], mo, md);
`ifdef DMEM_RMW_EN
            if (mo != 2'd3) mlat = 3;
`endif
            wr_cyc  = cyc + mlat - 1;
            wr_val  = (mlat == 3) ? 2'd3 : mo;
            wr_addr = ma;
          end
        end
        me.due   = cyc + mlat;
        me.port  = mp;
        exp_q.push_back(me);
        grant_log.push_back(mp);
        free_cyc = cyc + mlat;
        lw       = mp;
        if (mp == 1) acc1++; else acc0++;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the request has been taken
  task automatic issue(input int p, input logic [1:0] o, input logic [31:0] a, input logic [31:0] d);
    int start;
    int n;
    start = (p == 1) ? acc1 : acc0;
    if (p == 1) begin op1 = o; addr1 = a; wd1 = d; vld1 = 1'b1; end
    else        begin op0 = o; addr0 = a; wd0 = d; vld0 = 1'b1; end
    n = 0;
    while (((p == 1) ? acc1 : acc0) == start && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_in_time", {31'd0, n < 50}, 32'd1);
    if (p == 1) vld1 = 1'b0; else vld0 = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  logic [31:0] saved;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[20] = 32'd15;       ref_mem[20] = 32'd15;
    mem[16] = 32'd65340;    ref_mem[16] = 32'd65340;
    mem[24] = 32'd243;      ref_mem[24] = 32'd243;
    mem[28] = 32'd16772668; ref_mem[28] = 32'd16772668;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);

    issue(0, 2'd0, 32'd20, 32'd0);
    settle();

    issue(1, 2'd3, 32'd5, 32'hDEADBEEF);
    issue(1, 2'd0, 32'd5, 32'd0);
    settle();
    chk("sw5_word", mem[5], 32'hDEADBEEF);

    grant_log.delete();
    fork
      begin issue(0, 2'd0, 32'd16, 32'd0); issue(0, 2'd0, 32'd16, 32'd0); end
      begin issue(1, 2'd0, 32'd24, 32'd0); issue(1, 2'd0, 32'd24, 32'd0); end
    join
    settle();
    chk("alt_count", grant_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      chk("alt_order", grant_log[i], i % 2);

    issue(0, 2'd1, 32'd28, 32'h80);
    settle();
`ifdef DMEM_RMW_EN
    chk("sb28_word", mem[28], 32'h00FFEE80);
`else
    chk("sb28_word", mem[28], 32'hFFFFFF80);
`endif

    saved = mem[0];
    issue(0, 2'd3, 32'd64, 32'h1234_5678);
    settle();
    chk("oor_no_alias", mem[0], saved);

    saved = ref_mem[10];
    issue(0, 2'd3, 32'd10, 32'hCAFEF00D);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ref_mem[10] = saved;
    chk("abort_word", mem[10], saved);
    chk("abort_mem_a", mem_a, 32'd0);
    chk("abort_mem_wd", mem_wd, 32'd0);
    grant_log.delete();
    fork
      issue(0, 2'd0, 32'd3, 32'd0);
      issue(1, 2'd0, 32'd4, 32'd0);
    join
    settle();
    chk("post_rst_first", (grant_log.size() > 0) ? grant_log[0] : -1, 32'd0);

    fork
      for (int k = 0; k < 60; k++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        issue(0, 2'($urandom_range(0, 3)), 32'($urandom_range(0, 71)), $urandom);
      end
      for (int k = 0; k < 60; k++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        issue(1, 2'($urandom_range(0, 3)), 32'($urandom_range(0, 71)), $urandom);
      end
    join
    settle();

    chk("rsp_drained", exp_q.size(), 32'd0);
    for (int i = 0; i < DEPTH; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
